// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit slice.
// Holds the fetch FSM state enum, default datapath widths, the location of
// the opcode field inside an instruction word, and the no-op encoding.
package cpu_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 16;

  // Opcode is the top OPC_W bits of the instruction word (MSB-aligned).
  localparam int OPC_W = 6;
  localparam logic [OPC_W-1:0] OPC_NOOP = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // Bit index of the opcode LSB for a given instruction width.
  function automatic int opcode_lsb(input int instr_w);
    return instr_w - OPC_W;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and the memory.
// Signals:
//   imem_req  - read request (fetch unit -> memory)
//   imem_addr - read address (fetch unit -> memory)
//   imem_ack  - read complete, imem_data valid this cycle (memory -> fetch unit)
//   imem_data - instruction word (memory -> fetch unit)
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_data);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_data);

endinterface

// File: rtl/pc_counter.sv
// Program counter register with its next-pc mux.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (pc -> 0)
//   load_en_i  - update pc this edge
//   s_inc_i    - 1: pc+1 (wraps), 0: load target_i
//   target_i   - jump target
//   pc_o       - current program counter
module pc_counter
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en_i,
  input  logic            s_inc_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0] pc_q, pc_d;

  // Increment wraps naturally at 2^PC_W because the sum is truncated to PC_W.
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = s_inc_i ? (pc_q + PC_ONE) : target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> EXEC -> FETCH ... loop.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   imem         - instruction-memory bus (master side)
//   opcode       - opcode field of the instruction register
//   instr        - instruction register
//   instr_valid  - high in every EXEC cycle
//   s_inc, wez   - control-unit commands, sampled only in EXEC
//   alu_z        - ALU zero result, captured into z when wez is set
//   z            - registered zero flag
//   stall        - holds the unit in EXEC while high
//   pc           - current program counter
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       imem,
  output logic [OPC_W-1:0]   opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               s_inc,
  input  logic               wez,
  input  logic               alu_z,
  output logic               z,
  input  logic               stall,
  output logic [PC_W-1:0]    pc
);

  localparam int OPC_LSB = opcode_lsb(INSTR_W);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               z_q, z_d;
  logic               pc_load;
  logic               req;
  logic               valid;

  // imem_ack is only looked at in FETCH, and stall only in EXEC, so a
  // simultaneous stall+ack in FETCH still takes the ack.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    z_d     = z_q;
    pc_load = 1'b0;
    req     = 1'b0;
    valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          instr_d = imem.imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        valid = 1'b1;
        if (!stall) begin
          pc_load = 1'b1;
          if (wez) begin
            z_d = alu_z;
          end
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      z_q     <= z_d;
    end
  end

  pc_counter #(
    .PC_W(PC_W)
  ) u_pc_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load_en_i(pc_load),
    .s_inc_i  (s_inc),
    .target_i (instr_q[PC_W-1:0]),
    .pc_o     (pc)
  );

  // req/valid decode straight from state, so an async reset drops them at once.
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign instr_valid    = valid;
  assign instr          = instr_q;
  assign opcode         = instr_q[OPC_LSB +: OPC_W];
  assign z              = z_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode;
  logic [15:0] instr;
  logic        instr_valid;
  logic        s_inc = 1'b1;
  logic        wez = 1'b0;
  logic        alu_z = 1'b0;
  logic        z;
  logic        stall = 1'b0;
  logic [9:0]  pc;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.PC_W(10), .INSTR_W(16)) imem ();

  fetch_unit #(.PC_W(10), .INSTR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem.master),
    .opcode     (opcode),
    .instr      (instr),
    .instr_valid(instr_valid),
    .s_inc      (s_inc),
    .wez        (wez),
    .alu_z      (alu_z),
    .z          (z),
    .stall      (stall),
    .pc         (pc)
  );

  // Rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values, IDLE for one cycle, first request at address 0.
  task automatic test_reset();
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'h0000;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({imem.imem_req, instr_valid, pc, instr, opcode, z} !== {1'b0, 1'b0, 10'h000, 16'h0000, 6'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: req=%0b valid=%0b pc=%h instr=%h opc=%h z=%0b, required all zero",
               imem.imem_req, instr_valid, pc, instr, opcode, z);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (imem.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_release: req=%0b required 0", imem.imem_req);
    end
    tick();
    checks++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 10'h000}) begin
      errors++;
      $display("[TB] FAIL first_request: req=%0b addr=%h required req=1 addr=000", imem.imem_req, imem.imem_addr);
    end
  endtask

  // Zero-wait acks with s_inc=1: addresses 0,1,2; instr_valid every second cycle.
  task automatic test_sequential();
    imem.imem_ack  = 1'b1;
    imem.imem_data = 16'h0000;
    s_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem.imem_req, instr_valid, imem.imem_addr} !== {1'b1, 1'b0, 10'(i)}) begin
        errors++;
        $display("[TB] FAIL seq_fetch%0d: req=%0b valid=%0b addr=%h required req=1 valid=0 addr=%h",
                 i, imem.imem_req, instr_valid, imem.imem_addr, 10'(i));
      end
      tick();
      checks++;
      if ({imem.imem_req, instr_valid, instr} !== {1'b0, 1'b1, 16'h0000}) begin
        errors++;
        $display("[TB] FAIL seq_exec%0d: req=%0b valid=%0b instr=%h required req=0 valid=1 instr=0000",
                 i, imem.imem_req, instr_valid, instr);
      end
      tick();
    end
  endtask

  // Jump via 0x0405 lands on 0x005.
  task automatic test_jump();
    imem.imem_data = 16'h0405;
    s_inc = 1'b0;
    tick();
    checks++;
    if ({instr_valid, instr, opcode} !== {1'b1, 16'h0405, 6'h01}) begin
      errors++;
      $display("[TB] FAIL jump_exec: valid=%0b instr=%h opc=%h required valid=1 instr=0405 opc=01",
               instr_valid, instr, opcode);
    end
    tick();
    checks++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 10'h005}) begin
      errors++;
      $display("[TB] FAIL jump_target: req=%0b addr=%h required req=1 addr=005", imem.imem_req, imem.imem_addr);
    end
  endtask

  // Jump to 0x3FF then increment wraps to 0x000.
  task automatic test_wrap();
    imem.imem_data = 16'h03FF;
    s_inc = 1'b0;
    tick();
    tick();
    checks++;
    if (imem.imem_addr !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL wrap_setup: addr=%h required 3ff", imem.imem_addr);
    end
    imem.imem_data = 16'h0000;
    s_inc = 1'b1;
    tick();
    tick();
    checks++;
    if ({imem.imem_req, imem.imem_addr} !== {1'b1, 10'h000}) begin
      errors++;
      $display("[TB] FAIL wrap_increment: req=%0b addr=%h required req=1 addr=000", imem.imem_req, imem.imem_addr);
    end
  endtask

  // z loads on non-stalled EXEC with wez=1, holds with wez=0.
  task automatic test_zflag();
    wez = 1'b1;
    alu_z = 1'b1;
    tick();
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL z_before_exec_edge: z=%0b required 0", z);
    end
    tick();
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL z_set: z=%0b required 1", z);
    end
    wez = 1'b0;
    alu_z = 1'b0;
    tick();
    tick();
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL z_hold: z=%0b required 1", z);
    end
    wez = 1'b1;
    tick();
    tick();
    checks++;
    if ({z, imem.imem_addr} !== {1'b0, 10'h003}) begin
      errors++;
      $display("[TB] FAIL z_clear: z=%0b addr=%h required z=0 addr=003", z, imem.imem_addr);
    end
    wez = 1'b0;
  endtask

  // Ack after 3 waits (stall raised alongside ack), then 2 stall cycles in EXEC.
  task automatic test_wait_and_stall();
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'h1234;
    s_inc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        imem.imem_ack = 1'b1;
        stall = 1'b1;
      end
      checks++;
      if ({imem.imem_req, instr_valid, imem.imem_addr} !== {1'b1, 1'b0, 10'h003}) begin
        errors++;
        $display("[TB] FAIL wait_cycle%0d: req=%0b valid=%0b addr=%h required req=1 valid=0 addr=003",
                 i, imem.imem_req, instr_valid, imem.imem_addr);
      end
      tick();
    end
    // Ack with different data while in EXEC must be ignored; z must hold during stall.
    imem.imem_data = 16'hFFFF;
    wez = 1'b1;
    alu_z = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        stall = 1'b0;
        wez = 1'b0;
        imem.imem_ack = 1'b0;
      end
      checks++;
      if ({instr_valid, imem.imem_req, pc, instr, z} !== {1'b1, 1'b0, 10'h003, 16'h1234, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d: valid=%0b req=%0b pc=%h instr=%h z=%0b required valid=1 req=0 pc=003 instr=1234 z=0",
                 i, instr_valid, imem.imem_req, pc, instr, z);
      end
      tick();
    end
    alu_z = 1'b0;
    checks++;
    if ({instr_valid, imem.imem_req, imem.imem_addr, z} !== {1'b0, 1'b1, 10'h004, 1'b0}) begin
      errors++;
      $display("[TB] FAIL stall_release: valid=%0b req=%0b addr=%h z=%0b required valid=0 req=1 addr=004 z=0",
               instr_valid, imem.imem_req, imem.imem_addr, z);
    end
  endtask

  // Async reset in the middle of a FETCH; ack during reset ignored.
  task automatic test_reset_midfetch();
    checks++;
    if ({imem.imem_req, pc, opcode} !== {1'b1, 10'h004, 6'h04}) begin
      errors++;
      $display("[TB] FAIL midfetch_pre: req=%0b pc=%h opc=%h required req=1 pc=004 opc=04", imem.imem_req, pc, opcode);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({imem.imem_req, pc, opcode, instr_valid} !== {1'b0, 10'h000, 6'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midfetch_async: req=%0b pc=%h opc=%h valid=%0b required req=0 pc=000 opc=00 valid=0",
               imem.imem_req, pc, opcode, instr_valid);
    end
    imem.imem_ack  = 1'b1;
    imem.imem_data = 16'hABCD;
    tick();
    checks++;
    if ({imem.imem_req, instr} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL ack_in_reset: req=%0b instr=%h required req=0 instr=0000", imem.imem_req, instr);
    end
    imem.imem_ack = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({imem.imem_req, imem.imem_addr, instr} !== {1'b1, 10'h000, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL refetch_after_reset: req=%0b addr=%h instr=%h required req=1 addr=000 instr=0000",
               imem.imem_req, imem.imem_addr, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_wrap();
    test_zflag();
    test_wait_and_stall();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width; opcode = instr[INSTR_W-1 -: 6], jump target = instr[PC_W-1:0].
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  PC_W  read address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  memory read complete; imem_data valid this cycle.
REQ-008 SHALL have port imem_data  input  INSTR_W  instruction word.
REQ-009 SHALL have port opcode  output  6  opcode field of the instruction register, to the control unit.
REQ-010 SHALL have port instr  output  INSTR_W  instruction register contents.
REQ-011 SHALL have port instr_valid  output  1  high for each cycle in EXEC.
REQ-012 SHALL have port s_inc  input  1  from the control unit; 1 = pc+1, 0 = load jump target.
REQ-013 SHALL have port wez  input  1  from the control unit; update the Z flag.
REQ-014 SHALL have port alu_z  input  1  ALU zero result.
REQ-015 SHALL have port z  output  1  registered Z flag, to the control unit.
REQ-016 SHALL have port stall  input  1  hold in EXEC while high.
REQ-017 SHALL have port pc  output  PC_W  current program counter.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, EXEC.
REQ-019 IDLE: one cycle after reset release; imem_req=0; SHALL move to FETCH.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, instr <= imem_data and SHALL move to EXEC the next cycle; without ack, SHALL hold with the request and address stable.
REQ-021 imem_ack SHALL be ignored outside FETCH.
REQ-022 EXEC: instr_valid=1, imem_req=0; with stall=0, SHALL update pc and z in the same edge and return to FETCH; with stall=1, SHALL hold pc, z, and instr.
REQ-023 pc update in EXEC: s_inc=1 -> pc+1 modulo 2^PC_W (wrap 2^PC_W-1 -> 0); s_inc=0 -> instr[PC_W-1:0].
REQ-024 z update: on an EXEC non-stalled edge with wez=1, z <= alu_z; otherwise z is held.
REQ-025 One instruction SHALL take exactly 1 (FETCH, ack same cycle) + 1 (EXEC) = 2 cycles minimum; each ack-wait or stall cycle adds exactly 1.
REQ-026 opcode SHALL be driven combinationally from instr at all times; s_inc/wez SHALL only be sampled in EXEC.
REQ-027 Simultaneous stall=1 and imem_ack=1 in FETCH: ack SHALL be taken (stall has effect only in EXEC).

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, pc=0, instr=0 (opcode 000000 = noop), z=0, imem_req=0, instr_valid=0.
REQ-029 Reset asserted mid-FETCH SHALL drop imem_req immediately; an ack arriving during reset SHALL be ignored.
REQ-030 After release, the first request SHALL issue at address 0 on the second clock edge.

Structure
REQ-031 Package cpu_pkg SHALL hold the FSM state enum, PC_W/INSTR_W defaults, opcode field position, and OPC_NOOP.
REQ-032 The pc register and next-pc mux SHALL be a sub-module pc_counter (inputs: load-enable, s_inc, target; output: pc).

Verification
REQ-033 Reset then ack same cycle, imem_data=0x0000, s_inc=1 -> addresses 0,1,2 requested; instr_valid every 2nd cycle.
REQ-034 In EXEC, instr=0x0405 (jump), s_inc=0 -> next imem_addr=0x005.
REQ-035 pc=0x3FF, s_inc=1 -> next imem_addr=0x000.
REQ-036 In EXEC, wez=1, alu_z=1 -> z=1 next cycle; then wez=0, alu_z=0 -> z stays 1.
REQ-037 ack delayed 3 cycles, then stall=1 for 2 cycles in EXEC -> imem_req high 4 cycles with stable address; instr_valid high 3 cycles; pc unchanged until the stall drops.
REQ-038 reset=0 asserted in FETCH while imem_req=1 -> imem_req=0 and pc=0 before the next clock edge; opcode=000000.
